// File: rtl/secded_enc64_top.sv
`default_nettype none
// ============================================================================
//  Module      : secded_enc64_top
//  Description : (72,64) extended-Hamming SECDED encoder for the write path of
//                ECC-protected storage. The output register is loaded every
//                clock, so one word is encoded per cycle.
//
//                Codeword layout (Hamming position p maps to OUT[p-1]):
//                  - parity bits at positions 1,2,4,8,16,32,64
//                  - data bits at the remaining positions 3..71 in ascending
//                    order (IN[0] -> position 3, IN[63] -> position 71)
//                  - parity at 2^k = even parity over the data positions whose
//                    index has bit k set
//                  - OUT[71] = XOR of OUT[70:0] (overall parity)
//
//  Ports       : clk   - system clock, rising edge
//                rst_n - asynchronous active-low reset, clears all state
//                IN    - 64-bit data word to encode
//                OUT   - 72-bit registered codeword
//
//  Build option: ENC_IN_REG_EN - when defined, IN is registered before the
//                encode logic (latency 2 instead of 1). The codeword function
//                is the same in both builds.
//
//  Revision    : 1.0 - initial release
// ============================================================================

module secded_enc64_top (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] IN,
    output logic [71:0] OUT
);

    // ------------------------------------------------------------------------
    // Elaboration-time helpers describing the fixed bit layout.
    // ------------------------------------------------------------------------
    function automatic bit is_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    // Hamming position that carries data bit idx: the idx-th non-power-of-two
    // position counting upward from 3.
    function automatic int data_pos(input int idx);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 3; p <= 71; p++) begin
            if (!is_pow2(p)) begin
                if (cnt == idx) begin
                    pos = p;
                end
                cnt = cnt + 1;
            end
        end
        return pos;
    endfunction

    // Codeword-bit mask of the data positions covered by parity bit 2^k.
    function automatic logic [71:0] parity_mask(input int k);
        logic [71:0] m;
        m = '0;
        for (int p = 3; p <= 71; p++) begin
            if (!is_pow2(p) && (((p >> k) & 1) != 0)) begin
                m = m | (72'd1 << (p - 1));
            end
        end
        return m;
    endfunction

    // ------------------------------------------------------------------------
    // Optional input register
    // ------------------------------------------------------------------------
    logic [63:0] enc_data;

`ifdef ENC_IN_REG_EN
    logic [63:0] in_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q <= '0;
        end else begin
            in_q <= IN;
        end
    end

    assign enc_data = in_q;
`else
    assign enc_data = IN;
`endif

    // ------------------------------------------------------------------------
    // Data placement: spread the 64 data bits over their codeword positions,
    // leaving zeros in the parity slots and the overall-parity bit.
    // ------------------------------------------------------------------------
    logic [71:0] cw_data;

    for (genvar gi = 0; gi < 64; gi++) begin : g_data_place
        localparam int POS = data_pos(gi);
        assign cw_data[POS - 1] = enc_data[gi];
    end

    for (genvar gk = 0; gk < 7; gk++) begin : g_par_slot
        localparam int PPOS = 1 << gk;
        assign cw_data[PPOS - 1] = 1'b0;
    end

    assign cw_data[71] = 1'b0;

    // ------------------------------------------------------------------------
    // Hamming parity: each bit is an XOR reduction over a constant mask, so
    // an X on one data bit only reaches the parity bits that cover it.
    // ------------------------------------------------------------------------
    logic [6:0] ham_par;

    for (genvar gk = 0; gk < 7; gk++) begin : g_parity
        localparam logic [71:0] PMASK = parity_mask(gk);
        assign ham_par[gk] = ^(cw_data & PMASK);
    end

    // ------------------------------------------------------------------------
    // Codeword assembly and output register
    // ------------------------------------------------------------------------
    logic [71:0] out_d;
    logic [71:0] out_q;

    always_comb begin
        out_d     = cw_data;
        out_d[0]  = ham_par[0];
        out_d[1]  = ham_par[1];
        out_d[3]  = ham_par[2];
        out_d[7]  = ham_par[3];
        out_d[15] = ham_par[4];
        out_d[31] = ham_par[5];
        out_d[63] = ham_par[6];
        // Overall parity makes the whole 72-bit word XOR to zero, which lets
        // the decoder tell single from double errors.
        out_d[71] = ^out_d[70:0];
    end

    // All-zero is the codeword for data 0, so reset leaves OUT valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign OUT = out_q;

endmodule

`default_nettype wire

// File: tb/tb_secded_enc64_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_secded_enc64_top
//  Description : Self-checking bench for secded_enc64_top. Directed vectors
//                held in a table are streamed back-to-back and compared
//                against hand-computed constants or a syndrome-based layout
//                model; reset behaviour is exercised by hand-written
//                sequences. Each codeword is also checked for zero overall
//                parity and for correct single-bit-flip syndromes.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_secded_enc64_top;

`ifdef ENC_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam int NVEC = 8;

    logic        clk;
    logic        rst_n;
    logic [63:0] din;
    logic [71:0] dout;

    int n_vec;
    int n_fail;

    typedef struct {
        logic [63:0] din;
        logic [71:0] exp;
    } vec_t;

    vec_t vecs [NVEC];

    secded_enc64_top dut (
        .clk   (clk),
        .rst_n (rst_n),
        .IN    (din),
        .OUT   (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: place data bits, then build the parity bits as the
    // XOR of the positions of all set data bits (the classic syndrome form).
    function automatic logic [71:0] ref_encode(input logic [63:0] d);
        logic [71:0] c;
        logic [6:0]  syn;
        int          di;
        c   = '0;
        syn = '0;
        di  = 0;
        for (int p = 1; p <= 71; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p - 1] = d[di];
                if (d[di]) syn = syn ^ p[6:0];
                di = di + 1;
            end
        end
        for (int k = 0; k < 7; k++) c[(1 << k) - 1] = syn[k];
        c[71] = ^c[70:0];
        return c;
    endfunction

    function automatic logic [6:0] syndrome(input logic [71:0] c);
        logic [6:0] s;
        s = '0;
        for (int p = 1; p <= 71; p++) begin
            if (c[p - 1]) s = s ^ p[6:0];
        end
        return s;
    endfunction

    task automatic check72(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: OUT=%h expected %h", nm, act, exp);
        end
    endtask

    // Overall parity and single-bit-flip syndromes of a captured codeword.
    task automatic check_code(input int idx, input logic [71:0] cw);
        logic [71:0] f;
        logic [6:0]  s;
        logic [6:0]  exp_s;
        int          bad;
        n_vec = n_vec + 1;
        if ((^cw) !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL parity[%0d]: XOR of OUT=%b expected 0 (OUT=%h)", idx, ^cw, cw);
        end
        n_vec = n_vec + 1;
        bad = -1;
        for (int j = 0; j < 72; j++) begin
            f     = cw ^ (72'd1 << j);
            s     = syndrome(f);
            exp_s = (j == 71) ? 7'd0 : 7'(j + 1);
            if (s !== exp_s || (^f) !== 1'b1) bad = j;
        end
        if (bad >= 0) begin
            n_fail = n_fail + 1;
            $display("FAIL flip[%0d]: flipping bit %0d gives wrong syndrome/overall parity (OUT=%h)",
                     idx, bad, cw);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec  = 0;
        n_fail = 0;

        vecs[0] = '{64'h0000_0000_0000_0000, 72'h00_0000_0000_0000_0000};
        vecs[1] = '{64'h0000_0000_0000_0001, 72'h80_0000_0000_0000_0007};
        vecs[2] = '{64'h8000_0000_0000_0000, 72'hC0_8000_0000_0000_000B};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 72'hFF_FFFF_FFFF_FFFF_FFFF};
        vecs[4] = '{64'd1280925896923972120, ref_encode(64'd1280925896923972120)};
        vecs[5] = '{64'd3295280805934658495, ref_encode(64'd3295280805934658495)};
        vecs[6] = '{64'h5555_5555_5555_5555, ref_encode(64'h5555_5555_5555_5555)};
        vecs[7] = '{64'hDEAD_BEEF_0123_4567, ref_encode(64'hDEAD_BEEF_0123_4567)};

        // Reset held with all-ones input: clock edges must not load anything.
        rst_n = 1'b0;
        din   = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        check72("reset_async", dout, 72'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check72("reset_hold", dout, 72'h0);
        end

        // First capture happens on the first rising edge after release.
        @(negedge clk);
        rst_n = 1'b1;
        din   = 64'h0000_0000_0000_0001;
        repeat (LAT) @(posedge clk);
        #1;
        check72("first_capture", dout, 72'h80_0000_0000_0000_0007);

        // Back-to-back stream of the table: a new word every cycle, each
        // output compared LAT cycles after its input was applied.
        for (int i = 0; i < NVEC + LAT; i++) begin
            @(negedge clk);
            if (i >= LAT) begin
                check72($sformatf("vec[%0d]", i - LAT), dout, vecs[i - LAT].exp);
                check_code(i - LAT, dout);
            end
            din = (i < NVEC) ? vecs[i].din : 64'h0;
        end

        // Mid-stream reset: clears OUT before the next clock edge.
        @(negedge clk);
        din = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (LAT) @(posedge clk);
        #1;
        check72("pre_reset_all_ones", dout, 72'hFF_FFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        din = 64'h0000_0000_0000_0001;
        #2;
        rst_n = 1'b0;
        #1;
        check72("midstream_reset", dout, 72'h0);
        @(posedge clk);
        #1;
        check72("midstream_reset_hold", dout, 72'h0);

        // After release the word queued before reset must not reappear.
        @(negedge clk);
        rst_n = 1'b1;
        din   = 64'h8000_0000_0000_0000;
        @(posedge clk);
        #1;
        check72("post_reset_cycle1", dout,
                (LAT == 1) ? 72'hC0_8000_0000_0000_000B : 72'h0);
        @(negedge clk);
        din = 64'h0000_0000_0000_0001;
        repeat (LAT) @(posedge clk);
        #1;
        check72("post_reset_word", dout, 72'h80_0000_0000_0000_0007);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
